gate_checker: RTL and testbench

- Sequential stimulus-driver and response-checker for any 2-input combinational gate in the basic-gates set (gsnand and siblings).
- Drives the gate's a/b inputs through all four combinations, samples the gate's y output after a programmable settle time, and compares it with an expected truth table.
- Reports pass/fail, an error count and a per-vector failure map.
- Sits on the opposite side of the gate interface: it drives what the gate receives and reads what the gate produces.

---
 rtl/gate_checker.sv | 122 ++++++++++++
 tb/tb_gate_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// Stimulus driver and response checker for a 2-input combinational gate.
// Walks {a,b} through 00..11, samples y SETTLE cycles after each update and scores it against TRUTH.
module gate_checker #(
    parameter logic [3:0]  TRUTH  = 4'b0111,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned ERR_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [3:0]       fail_nxt;

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        a_nxt     = a;
        b_nxt     = b;
        busy_nxt  = busy;
        done_nxt  = done;
        pass_nxt  = pass;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = WAIT;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    err_nxt   = '0;
                    fail_nxt  = '0;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    if (y != TRUTH[idx]) begin
                        err_nxt       = err_count + ERR_W'(1);
                        fail_nxt[idx] = 1'b1;
                    end
                    if (idx != IDX_W'(3)) begin
                        idx_nxt        = idx + IDX_W'(1);
                        {a_nxt, b_nxt} = idx + IDX_W'(1);
                        cnt_nxt        = '0;
                    end else begin
                        // Pass must reflect the final sample too, so it uses the updated count.
                        state_nxt = DONE;
                        a_nxt     = 1'b0;
                        b_nxt     = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == '0);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_nxt;
            fail_vec  <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: a NAND checker (SETTLE=2) and an OR checker (SETTLE=1) share start/rst,
// each driving a table-defined gate model; a reference model queues expected runs for a negedge monitor.
module tb_gate_checker;

    typedef struct {
        int         inst;
        int         launch;
        int         done_cyc;
        logic [3:0] fail;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ytab0, ytab1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic rst_edge = 1'b0;
    bit   active [2] = '{1'b0, 1'b0};
    int   busy_until [2] = '{0, 0};
    logic done_prev [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    // Gate under test is just a lookup on the current stimulus.
    assign y0 = ytab0[{a0, b0}];
    assign y1 = ytab1[{a1, b1}];

    gate_checker #(.TRUTH(4'b0111), .SETTLE(2)) u_nand (
        .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    gate_checker #(.TRUTH(4'b1110), .SETTLE(1)) u_or (
        .clk(clk), .rst(rst), .start(start), .a(a1), .b(b1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [3:0] truth_of(input int i);
        return (i == 0) ? 4'b0111 : 4'b1110;
    endfunction

    function automatic logic [3:0] ytab_of(input int i);
        return (i == 0) ? ytab0 : ytab1;
    endfunction

    task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%h expected=%h", name, i, cyc, act, exp);
        end
    endtask

    // Reference model: a run is accepted when start is seen and the previous run has finished.
    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = rst;
            if (rst) begin
                q.delete();
                active = '{1'b0, 1'b0};
            end else if (start) begin
                for (int i = 0; i < 2; i++) begin
                    if (!active[i] || cyc > busy_until[i]) begin
                        exp_t e;
                        e.inst     = i;
                        e.launch   = cyc;
                        e.done_cyc = cyc + 4 * settle_of(i);
                        e.fail     = ytab_of(i) ^ truth_of(i);
                        q.push_back(e);
                        active[i]     = 1'b1;
                        busy_until[i] = e.done_cyc;
                    end
                end
            end
        end
    end

    task automatic mon(input int i, input logic [1:0] ab, input logic bsy, input logic dn,
                       input logic ps, input logic [2:0] ec, input logic [3:0] fv);
        int k;
        k = -1;
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].inst == i) begin
                k = j;
                break;
            end
        end
        if (rst_edge) begin
            chk("reset_state", i, 16'({ab, bsy, dn, ps, ec, fv}), 16'd0);
        end else if (k < 0) begin
            chk("idle_outputs", i, 16'({ab, bsy}), 16'd0);
            chk("spurious_done", i, 16'(dn && !done_prev[i]), 16'd0);
        end else begin
            exp_t e;
            e = q[k];
            if (cyc < e.done_cyc) begin
                chk("run_vector", i, 16'({bsy, dn, ab}),
                    16'({2'b10, 2'((cyc - e.launch) / settle_of(i))}));
            end else begin
                chk("run_result", i, 16'({dn, bsy, ab, ps, ec, fv}),
                    16'({1'b1, 1'b0, 2'b00, e.fail == 4'd0, 3'($countones(e.fail)), e.fail}));
                q.delete(k);
            end
        end
        done_prev[i] = dn;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                mon(0, {a0, b0}, busy0, done0, pass0, err0, fail0);
                mon(1, {a1, b1}, busy1, done1, pass1, err1, fail1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1 || q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            $display("FAIL wait_idle timeout cyc=%0d busy0=%b busy1=%b pending=%0d", cyc, busy0, busy1, q.size());
            $fatal(1, "run did not finish");
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : stimulus
        rst   = 1'b1;
        start = 1'b0;
        ytab0 = 4'b0111;
        ytab1 = 4'b1110;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal NAND, stuck-at-1, and AND driven into the NAND checker.
        pulse_start();
        wait_idle();
        ytab0 = 4'b1111;
        pulse_start();
        wait_idle();
        ytab0 = 4'b1000;
        pulse_start();
        wait_idle();

        // Re-pulse mid-run is ignored, then start held high relaunches back to back.
        ytab0 = 4'b0111;
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_start();
        wait_idle();
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset five cycles into a stuck-at run, with start high on the reset edge.
        ytab0 = 4'b1111;
        pulse_start();
        repeat (4) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        wait_idle();

        // Randomized gate behaviour, start timing, mid-run restarts and aborts.
        for (int r = 0; r < 24; r++) begin
            ytab0 = 4'($urandom);
            ytab1 = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start();
            case ($urandom_range(0, 3))
                0: begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    pulse_start();
                end
                1: begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end
                default: ;
            endcase
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
